// File: rtl/sort_input_loader.sv
// sort_input_loader: gathers a valid/ready element stream into a register array for sort_top.
// Define SORT_LOADER_PAD_EN to pad short frames with all-ones so unused slots sort high.
module sort_input_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [DATA_WIDTH-1:0]                        in_data,
    input  logic                                         in_last,
    output logic [(1<<ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]   unsorted_array,
    output logic                                         array_valid,
    output logic [ADDR_WIDTH:0]                          array_count,
    input  logic                                         array_ack,
    output logic                                         trunc_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);

`ifdef SORT_LOADER_PAD_EN
    typedef enum logic [1:0] {FILL, PAD, HOLD} state_t;
`else
    typedef enum logic [1:0] {FILL, HOLD} state_t;
`endif

    state_t state, state_nxt;
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] ptr_inc;
    logic [ADDR_WIDTH-1:0] slot;
    logic accept;

    assign ptr_inc = wr_ptr + 1'b1;
    assign slot = wr_ptr[ADDR_WIDTH-1:0];
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= FILL;
        else
            state <= state_nxt;
    end

    // wr_ptr tracks array_count during FILL, so ptr_inc==FULL marks the last slot in both FILL and PAD
    always_comb begin
        state_nxt = state;
        case (state)
`ifdef SORT_LOADER_PAD_EN
            FILL: if (accept && (ptr_inc == FULL || in_last))
                state_nxt = ptr_inc == FULL ? HOLD : PAD;
            PAD: if (ptr_inc == FULL)
                state_nxt = HOLD;
`else
            FILL: if (accept && (ptr_inc == FULL || in_last))
                state_nxt = HOLD;
`endif
            HOLD: if (array_ack)
                state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb in_ready = (state == FILL) && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            unsorted_array <= '0;
            wr_ptr <= '0;
            array_count <= '0;
            array_valid <= 1'b0;
            trunc_err <= 1'b0;
        end else begin
            array_valid <= state_nxt == HOLD;
            if (accept) begin
                unsorted_array[slot] <= in_data;
                wr_ptr <= ptr_inc;
                array_count <= array_count + 1'b1;
                trunc_err <= ptr_inc == FULL && !in_last;
            end
`ifdef SORT_LOADER_PAD_EN
            if (state == PAD) begin
                unsorted_array[slot] <= '1;
                wr_ptr <= ptr_inc;
            end
`endif
            if (state == HOLD && array_ack) begin
                wr_ptr <= '0;
                array_count <= '0;
                trunc_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sort_input_loader.sv
// tb_sort_input_loader: directed and randomized frames checked against a frame-level model of the loader.
module tb_sort_input_loader;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic array_ack = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic in_ready, array_valid, trunc_err;
    logic [DEPTH-1:0][DW-1:0] unsorted_array;
    logic [AW:0] array_count;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] m_arr [DEPTH];
    int m_cnt;
    bit m_trunc;
    logic [DW-1:0] fd [DEPTH];

    sort_input_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .unsorted_array(unsorted_array),
        .array_valid(array_valid),
        .array_count(array_count),
        .array_ack(array_ack),
        .trunc_err(trunc_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        foreach (m_arr[j]) m_arr[j] = '0;
        m_cnt = 0;
        m_trunc = 0;
    endtask

    task automatic chk_array(input string tag);
        for (int j = 0; j < DEPTH; j++)
            chk($sformatf("%s_slot%0d", tag, j), unsorted_array[j], m_arr[j]);
    endtask

    task automatic chk_hold(input string tag);
        chk({tag, "_count"}, array_count, m_cnt);
        chk({tag, "_trunc"}, trunc_err, m_trunc);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_valid"}, array_valid, 1);
        chk_array(tag);
    endtask

    task automatic send_beats(input int n, input bit last, input bit noise);
        for (int i = 0; i < n; i++) begin
            while (noise && $urandom_range(2) == 0) begin
                in_valid = 1'b0;
                in_data = DW'($urandom);
                in_last = 1'($urandom);
                array_ack = 1'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data = fd[i];
            in_last = last && i == n - 1;
            array_ack = noise ? 1'($urandom) : 1'b0;
            chk("fill_ready", in_ready, 1);
            m_arr[m_cnt] = fd[i];
            m_cnt++;
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        array_ack = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input bit last);
        int want = 0;
        int k = 0;
        if (m_cnt == DEPTH && !last) m_trunc = 1;
`ifdef SORT_LOADER_PAD_EN
        want = DEPTH - m_cnt;
        for (int j = m_cnt; j < DEPTH; j++) m_arr[j] = '1;
`endif
        while (array_valid !== 1'b1 && k < 3 * DEPTH) begin
            tick();
            k++;
        end
        chk({tag, "_latency"}, k, want);
        chk_hold(tag);
    endtask

    task automatic send_frame(input string tag, input int n, input bit last, input bit noise);
        send_beats(n, last, noise);
        finish_frame(tag, last);
    endtask

    task automatic ack();
        array_ack = 1'b1;
        tick();
        array_ack = 1'b0;
        m_cnt = 0;
        m_trunc = 0;
        chk("ack_valid", array_valid, 0);
        chk("ack_ready", in_ready, 1);
        chk("ack_count", array_count, 0);
        chk("ack_trunc", trunc_err, 0);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", array_valid, 0);
        chk("rst_count", array_count, 0);
        chk("rst_trunc", trunc_err, 0);
        chk_array("rst");
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("post_rst_ready", in_ready, 1);

        fd = '{8'd5, 8'd3, 8'd8, 8'd6, 8'd2, 8'd4, 8'd7, 8'd1,
               8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_frame("short", 8, 1'b1, 1'b0);

        in_valid = 1'b1;
        in_data = 8'hAA;
        repeat (3) begin
            tick();
            chk("bp_ready", in_ready, 0);
            chk_array("bp");
        end
        array_ack = 1'b1;
        tick();
        array_ack = 1'b0;
        m_cnt = 0;
        m_trunc = 0;
        chk("bp_ack_valid", array_valid, 0);
        chk("bp_ack_ready", in_ready, 1);
        chk("bp_ack_count", array_count, 0);
        tick();
        in_valid = 1'b0;
        m_arr[0] = 8'hAA;
        m_cnt = 1;
        chk("bp_slot0", unsorted_array[0], 8'hAA);
        chk("bp_count", array_count, 1);
        for (int i = 0; i < 15; i++) fd[i] = DW'($urandom);
        send_frame("bp_full", 15, 1'b0, 1'b0);

        ack();
        for (int i = 0; i < DEPTH; i++) fd[i] = DW'(DEPTH - i);
        send_frame("full", DEPTH, 1'b0, 1'b0);

        ack();
        for (int i = 0; i < DEPTH; i++) fd[i] = DW'($urandom);
        send_frame("full_last", DEPTH, 1'b1, 1'b0);

        ack();
        fd[0] = 8'd3;
        fd[1] = 8'd1;
        send_frame("frame_a", 2, 1'b1, 1'b0);
        ack();
        fd[0] = 8'd9;
        send_frame("frame_b", 1, 1'b1, 1'b0);

        ack();
        for (int i = 0; i < 4; i++) fd[i] = DW'($urandom);
        send_beats(4, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        chk("midrst_valid", array_valid, 0);
        chk("midrst_count", array_count, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_trunc", trunc_err, 0);
        chk_array("midrst");
        @(negedge clk);
        reset = 1'b1;
        tick();
        fd[0] = 8'd5;
        fd[1] = 8'd3;
        send_frame("after_rst", 2, 1'b1, 1'b0);

        repeat (12) begin
            int n;
            bit last;
            ack();
            n = $urandom_range(1, DEPTH);
            last = n < DEPTH ? 1'b1 : 1'($urandom);
            for (int i = 0; i < DEPTH; i++) fd[i] = DW'($urandom);
            send_frame("rand", n, last, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sort_input_loader.md
# sort_input_loader

Upstream feeder for `sort_top`. It collects a serial stream of `DATA_WIDTH`-bit elements over a valid/ready handshake into a `1<<ADDR_WIDTH`-entry register array. It then presents the array as `unsorted_array`, together with a frame-valid flag, until the sorter acknowledges it. Frames shorter than the array are optionally padded so that unused slots sort to the top end.

## Interface
- `DATA_WIDTH`, 8: element width in bits.
- `ADDR_WIDTH`, 4: log2 of array depth; DEPTH = 1<<ADDR_WIDTH.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input element present.
- `in_ready`  out  1  loader accepts the element this cycle.
- `in_data`  in  DATA_WIDTH  input element.
- `in_last`  in  1  final element of the frame; qualified by `in_valid`.
- `unsorted_array`  out  DEPTH x DATA_WIDTH  assembled frame; element i at index i.
- `array_valid`  out  1  frame complete and stable.
- `array_count`  out  ADDR_WIDTH+1  number of real (non-pad) elements in the frame, 1..DEPTH.
- `array_ack`  in  1  consumer has taken the frame.
- `trunc_err`  out  1  frame hit DEPTH elements without `in_last`.

## Operation
- Beat accepted when `in_valid && in_ready`.
- States are FILL, PAD and HOLD. FILL is the reset state.
- **FILL**
  - `in_ready`=1.
  - Each accepted beat writes `in_data` to `unsorted_array[wr_ptr]` and increments `wr_ptr` and `array_count`.
  - Accepted beat with `in_last`=1 and post-write count < DEPTH → PAD.
  - Accepted beat that makes count == DEPTH → HOLD, whether or not `in_last` is set.
  - If that beat has `in_last`=0, set `trunc_err`=1. The next beat starts a new frame.
- **PAD**
  - `in_ready`=0.
  - Each cycle writes all-ones to `unsorted_array[wr_ptr]` and increments `wr_ptr`.
  - Does not change `array_count`.
  - After slot DEPTH-1 is written → HOLD.
- **HOLD**
  - `array_valid`=1, `in_ready`=0.
  - Array, `array_count` and `trunc_err` are frozen.
  - `array_ack`=1 → FILL; `wr_ptr`, `array_count` and `trunc_err` clear.
- Array contents are never cleared except by reset. Unwritten slots keep their previous values.
- `array_ack` outside HOLD is ignored.
- `in_data` and `in_last` are ignored when the beat is not accepted.
- `wr_ptr` is ADDR_WIDTH+1 bits internally and never wraps within a frame.

## Timing
- Reset values, applied asynchronously while `reset`=0:
  - state FILL, all array entries 0.
  - `array_count`=0, `array_valid`=0, `trunc_err`=0, `in_ready`=0.
- `in_ready` = (state==FILL) && `reset`. It is 1 from the first cycle after reset deasserts.
- `array_valid`, `array_count`, `trunc_err` and `unsorted_array` are registered outputs.
- **Latency, last beat at edge T:**
  - Full frame: `array_valid`=1 after edge T.
  - Short frame with n elements: DEPTH-n PAD cycles, then `array_valid`=1 after edge T+DEPTH-n.
- **Ack handling:**
  - `array_ack` sampled at edge A with `array_valid`=1 → `array_valid`=0 and `in_ready`=1 after edge A.
  - The first beat of the next frame can be accepted at edge A+1.
- No combinational path from `in_valid` to `in_ready`.
- Reset asserted mid-FILL or mid-PAD discards the partial frame immediately.

## Configuration
- Macro `SORT_LOADER_PAD_EN`.
- **Defined:** PAD state exists as described; short frames are padded with {DATA_WIDTH{1'b1}}.
- **Undefined:** PAD state is removed.
  - `in_last` goes directly to HOLD; `array_valid`=1 on the cycle after the last beat.
  - Slots >= `array_count` keep stale or reset values. The consumer must use `array_count`.

## Test plan
- **Short frame with padding.** DEPTH=16, PAD_EN defined. Stream 5,3,8,6,2,4,7,1 with `in_last` on the 8th beat. Required:
  - Slots 0..7 equal the input in order; slots 8..15 = 255.
  - `array_count`=8, `trunc_err`=0.
  - `array_valid` rises 8 cycles after the last beat.
- **Full frame without `in_last`.** Stream 16 beats of values 16..1 with no `in_last`. Required:
  - HOLD with `array_count`=16, `trunc_err`=1.
  - `array_valid` rises the cycle after the 16th beat.
- **Backpressure.** Hold `in_valid`=1 with data 0xAA throughout HOLD. Required:
  - `in_ready`=0 and the array is unchanged.
  - After `array_ack`, 0xAA lands in slot 0 one cycle later and `array_count`=1.
- **Back-to-back frames.** Frame A (3,1, last), then ack, then frame B (9, last). Required:
  - B gives slot 0=9, `array_count`=1, slots 1..15=255.
  - `trunc_err` is cleared by the ack.
- **Reset mid-frame.** Pull `reset` low after 4 accepted beats. Required, immediately:
  - `array_valid`=0, `array_count`=0, all slots 0, `in_ready`=0.
  - After release, a 2-element frame assembles normally.
- **PAD_EN undefined.** Stream 5,3 with last. Required:
  - `array_valid`=1 on the next cycle, `array_count`=2.
  - Slots 2..15 retain their reset value 0.
